// File: rtl/rv32i_types.sv
// Shared CDB types and sizing constants used by the arbiter, ROB and reservation stations.
package rv32i_types;

  localparam int unsigned ROB_IDX_W = 4;
  // CDB_SIZE in the ROB/RS is derived from this lane count.
  localparam int unsigned CDB_LANES = 2;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [31:0]          v;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Rotating-priority picker: grants up to NUM_LANES valid requesters starting at ptr,
// reporting the lane each winner maps to and the index of the last winner.
module rr_multi_picker #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned PTR_W     = $clog2(NUM_REQ),
  parameter int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [PTR_W-1:0]               ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0][LANE_W-1:0] lane_of,
  output logic [PTR_W-1:0]               last_idx,
  output logic                           any_grant
);

  always_comb begin
    int unsigned     cnt;
    int unsigned     idx;
    logic [PTR_W-1:0] sel;
    grant    = '0;
    lane_of  = '0;
    last_idx = '0;
    cnt      = 0;
    idx      = 0;
    sel      = '0;
    for (int unsigned s = 0; s < NUM_REQ; s++) begin
      idx = (32'(ptr) + s) % NUM_REQ;
      sel = PTR_W'(idx);
      if (valid[sel] && (cnt < NUM_LANES)) begin
        grant[sel]   = 1'b1;
        lane_of[sel] = LANE_W'(cnt);
        last_idx     = sel;
        cnt          = cnt + 1;
      end
    end
  end

  assign any_grant = |grant;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: shares NUM_LANES result-bus lanes among NUM_REQ functional units with rotating
// priority, registering the winners onto the CDB one cycle after the handshake.
module cdb_arbiter import rv32i_types::*; #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_LANES = CDB_LANES,
  parameter int unsigned ROB_DEPTH = ROB_IDX_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROB_DEPTH-1:0]   req_rob,
  input  logic [NUM_REQ-1:0][31:0]            req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_LANES-1:0]                cdb_valid,
  output logic [NUM_LANES-1:0][ROB_DEPTH-1:0] cdb_rob,
  output logic [NUM_LANES-1:0][31:0]          cdb_rd_v,
  output logic                                arb_stall,
  output logic [15:0]                         stall_cnt
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef struct packed {
    logic                 valid;
    logic [ROB_DEPTH-1:0] rob;
    logic [31:0]          v;
  } lane_t;

  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  lane_t [NUM_LANES-1:0]          lane_q, lane_d;
  logic [15:0]                    stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0][LANE_W-1:0] lane_of;
  logic [PTR_W-1:0]               last_idx;
  logic                           any_grant;

  rr_multi_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_LANES (NUM_LANES),
    .PTR_W     (PTR_W),
    .LANE_W    (LANE_W)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .lane_of   (lane_of),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  assign req_ready = (rst || flush) ? '0 : grant;
  assign arb_stall = (|(req_valid & ~req_ready)) & ~flush;

  // Ungranted lanes stay all-zero so the CDB never shows stale tags.
  always_comb begin
    lane_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        lane_d[lane_of[i]] = '{valid: 1'b1, rob: req_rob[i], v: req_data[i]};
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  assign stall_cnt_d = (arb_stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      lane_q      <= flush ? '0 : lane_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign cdb_valid[k] = lane_q[k].valid;
    assign cdb_rob[k]   = lane_q[k].rob;
    assign cdb_rd_v[k]  = lane_q[k].v;
  end

  assign stall_cnt = stall_cnt_q;

  a_max_grants: assert property (@(posedge clk) $countones(req_ready) <= NUM_LANES);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_chk
    a_no_retract: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i] && !flush) |=>
      (req_valid[i] && $stable(req_rob[i]) && $stable(req_data[i])));
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_dup_o
    for (genvar j = k + 1; j < NUM_LANES; j++) begin : g_dup_i
      a_no_dup_rob: assert property (@(posedge clk) disable iff (rst)
        (cdb_valid[k] && cdb_valid[j]) |-> (cdb_rob[k] != cdb_rob[j]));
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a scan-order reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_cdb_arbiter;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_rob;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [1:0]       cdb_valid;
  logic [1:0][3:0]  cdb_rob;
  logic [1:0][31:0] cdb_rd_v;
  logic             arb_stall;
  logic [15:0]      stall_cnt;

  cdb_arbiter #(
    .NUM_REQ   (4),
    .NUM_LANES (2),
    .ROB_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rob   (req_rob),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob),
    .cdb_rd_v  (cdb_rd_v),
    .arb_stall (arb_stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lanes the CDB must show now, pointer, stall count.
  int          m_ptr = 0;
  logic [15:0] m_stall = '0;
  logic [1:0]  m_lv = '0;
  logic [1:0][3:0]  m_lr = '0;
  logic [1:0][31:0] m_ld = '0;
  logic [3:0]  m_grant = '0;
  bit          m_live = 0;
  int          preload_cnt = 0;
  int          m_seen_preload = 0;

  always @(negedge clk) begin
    int c;
    int last;
    int idx;
    logic [3:0] g;
    logic ex_stall;
    logic [1:0] nv;
    logic [1:0][3:0] nr;
    logic [1:0][31:0] nd;
    if (preload_cnt != m_seen_preload) begin
      m_stall = 16'hFFFE;
      m_seen_preload = preload_cnt;
    end
    g = '0; c = 0; last = -1; nv = '0; nr = '0; nd = '0;
    if (!rst && !flush) begin
      for (int s = 0; s < 4; s++) begin
        idx = (m_ptr + s) % 4;
        if (req_valid[idx] && c < 2) begin
          g[idx] = 1'b1;
          nv[c] = 1'b1;
          nr[c] = req_rob[idx];
          nd[c] = req_data[idx];
          c++;
          last = idx;
        end
      end
    end
    ex_stall = !flush && ((req_valid & ~g) != 4'b0);
    m_grant = g;
    if (m_live) begin
      chk("m_req_ready", req_ready, g);
      chk("m_arb_stall", arb_stall, ex_stall);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_cdb_valid", cdb_valid, m_lv);
      for (int k = 0; k < 2; k++) begin
        chk("m_cdb_rob", cdb_rob[k], m_lr[k]);
        chk("m_cdb_rd_v", cdb_rd_v[k], m_ld[k]);
      end
    end
    if (rst) begin
      m_live = 1;
      m_ptr = 0; m_stall = '0; m_lv = '0; m_lr = '0; m_ld = '0;
    end else if (flush) begin
      m_ptr = 0; m_lv = '0; m_lr = '0; m_ld = '0;
    end else begin
      m_lv = nv; m_lr = nr; m_ld = nd;
      if (c > 0) m_ptr = (last + 1) % 4;
      if (ex_stall && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
  end

  int seq [4] = '{0, 0, 0, 0};
  int wt  [4] = '{0, 0, 0, 0};
  int gcnt[4] = '{0, 0, 0, 0};

  task automatic new_pkt(input int i);
    seq[i]++;
    req_rob[i]  = 4'(i * 4 + seq[i] % 4);
    req_data[i] = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '1;
    @(negedge clk);
    chk("rst_ready_a", req_ready, 4'b0000);
    @(negedge clk);
    chk("rst_ready_b", req_ready, 4'b0000);
    chk("rst_cdb_valid", cdb_valid, 2'b00);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    next_cycle();
    rst = 1'b0; req_valid = '0;
  endtask

  initial begin
    bit pf;
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_rob = '0; req_data = '0;

    // Reset with all requesters valid
    do_reset();

    // All four valid, two lanes: pairs (0,1) then (2,3)
    for (int i = 0; i < 4; i++) begin
      req_rob[i] = 4'(i + 1);
      req_data[i] = 32'(i * 16);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t2_grant01", req_ready, 4'b0011);
    next_cycle();
    req_valid = 4'b1100;
    @(negedge clk);
    chk("t2_grant23", req_ready, 4'b1100);
    chk("t2_c1_valid", cdb_valid, 2'b11);
    chk("t2_c1_rob0", cdb_rob[0], 4'd1);
    chk("t2_c1_dat0", cdb_rd_v[0], 32'h00);
    chk("t2_c1_rob1", cdb_rob[1], 4'd2);
    chk("t2_c1_dat1", cdb_rd_v[1], 32'h10);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t2_c2_rob0", cdb_rob[0], 4'd3);
    chk("t2_c2_dat0", cdb_rd_v[0], 32'h20);
    chk("t2_c2_rob1", cdb_rob[1], 4'd4);
    chk("t2_c2_dat1", cdb_rd_v[1], 32'h30);
    next_cycle();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t2_ptr_wrap", req_ready, 4'b0011);
    next_cycle();
    do_reset();

    // Lone requester 2; pointer lands on 3
    req_valid = 4'b0100; req_rob[2] = 4'd7; req_data[2] = 32'h77;
    @(negedge clk);
    chk("t3_grant2", req_ready, 4'b0100);
    next_cycle();
    req_rob[2] = 4'd5; req_data[2] = 32'hAB;
    @(negedge clk);
    chk("t3_regrant2", req_ready, 4'b0100);
    chk("t3_no_stall", arb_stall, 1'b0);
    chk("t3_lane0_rob", cdb_rob[0], 4'd7);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t3_valid", cdb_valid, 2'b01);
    chk("t3_lane0_dat", cdb_rd_v[0], 32'hAB);
    chk("t3_lane1_rob", cdb_rob[1], 4'd0);
    chk("t3_lane1_dat", cdb_rd_v[1], 32'd0);
    next_cycle();
    req_valid = 4'b1011;
    new_pkt(0); new_pkt(1); new_pkt(3);
    @(negedge clk);
    chk("t3_from_ptr3", req_ready, 4'b1001);
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t3_then_1", req_ready, 4'b0010);
    next_cycle();
    do_reset();

    // Flush with pointer at 1: no grants, lanes cleared, pointer back to 0
    req_valid = 4'b0001; new_pkt(0);
    @(negedge clk);
    chk("t5_pre", req_ready, 4'b0001);
    next_cycle();
    req_valid = 4'b0111; flush = 1'b1;
    new_pkt(0); new_pkt(1); new_pkt(2);
    @(negedge clk);
    chk("t5_flush_ready", req_ready, 4'b0000);
    chk("t5_flush_cdb_held", cdb_valid, 2'b01);
    chk("t5_flush_stall", arb_stall, 1'b0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_cdb_cleared", cdb_valid, 2'b00);
    chk("t5_ptr_zero", req_ready, 4'b0011);
    next_cycle();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_both_out", cdb_valid, 2'b11);
    next_cycle();
    do_reset();

    // Sustained contention and stall counter saturation
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) new_pkt(i);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      chk("t4_stall", arb_stall, 1'b1);
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcnt[i]++;
      next_cycle();
      for (int i = 0; i < 4; i++) if (m_grant[i]) new_pkt(i);
    end
    @(negedge clk);
    chk("t4_stall_cnt10", stall_cnt, 16'd10);
    for (int i = 0; i < 4; i++) chk("t4_grants5", 64'(gcnt[i]), 64'd5);
    next_cycle();
    for (int i = 0; i < 4; i++) if (m_grant[i]) new_pkt(i);
    force dut.stall_cnt_q = 16'hFFFE;
    preload_cnt++;
    #1;
    release dut.stall_cnt_q;
    @(negedge clk);
    chk("t4_preload", stall_cnt, 16'hFFFE);
    for (int n = 0; n < 2; n++) begin
      next_cycle();
      for (int i = 0; i < 4; i++) if (m_grant[i]) new_pkt(i);
      @(negedge clk);
      chk("t4_saturate", stall_cnt, 16'hFFFF);
    end
    next_cycle();
    do_reset();

    // Random traffic with occasional flushes
    pf = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !flush) begin
          if (req_ready[i]) wt[i] = 0;
          else begin
            wt[i]++;
            chk("no_starve", 64'(wt[i] < 2), 64'd1);
          end
        end else begin
          wt[i] = 0;
        end
      end
      next_cycle();
      pf = flush;
      flush = ($urandom_range(39) == 0);
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && (m_grant[i] || pf)) begin
          req_valid[i] = $urandom_range(1);
          new_pkt(i);
        end else if (!req_valid[i] && $urandom_range(1) == 1) begin
          req_valid[i] = 1'b1;
          new_pkt(i);
        end
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
